// File: rtl/bin2gray_counter.sv
// bin2gray_counter
// Up/down binary counter with a registered Gray-coded view of the count.
// The Gray code is computed from the next-state binary value and stored in
// its own flop, so gray_out, bin_out and wrap always update on the same edge
// and gray_out never passes through combinational logic after the flops.

module bin2gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    // Binary-reflected Gray encoding: adjacent binary values differ in one bit.
    function automatic logic [WIDTH-1:0] encode(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q;

    logic [WIDTH-1:0] bin_d;
    logic             wrap_d;

    // Next-state selection: load beats a step; a step wraps modulo 2^WIDTH.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d  = load_bin;
            wrap_d = 1'b0;
        end else if (en) begin
            if (up_dn) begin
                bin_d  = bin_q + ONE;
                wrap_d = (bin_q == ALL_ONES);
            end else begin
                bin_d  = bin_q - ONE;
                wrap_d = (bin_q == ZERO);
            end
        end
    end

    // State registers; reset clears everything immediately, without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= ZERO;
            gray_q <= ZERO;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= encode(bin_d);
            wrap_q <= wrap_d;
        end
    end

    assign gray_out = gray_q;
    assign bin_out  = bin_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_bin2gray_counter.sv
// Directed testbench for bin2gray_counter (WIDTH = 4).

module tb_bin2gray_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_bin;
    logic [3:0] gray_out;
    logic [3:0] bin_out;
    logic       wrap;

    int checks;
    int errors;

    bin2gray_counter #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_bin (load_bin),
        .gray_out (gray_out),
        .bin_out  (bin_out),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference Gray-to-binary decoder used for loopback checking.
    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_bin = 4'd0;
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (gray_out !== 4'b0000 || bin_out !== 4'b0000 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got gray=%b bin=%b wrap=%b exp 0000 0000 0", gray_out, bin_out, wrap);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_count_up();
        logic [3:0] exp_gray [0:16];
        logic [3:0] exp_bin;
        logic [3:0] prev_gray;
        int wraps;
        exp_gray = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                     4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        do_reset();
        exp_bin = 4'd0;
        wraps = 0;
        checks++;
        if (gray_out !== exp_gray[0]) begin
            errors++;
            $display("FAIL up_start got %b exp %b", gray_out, exp_gray[0]);
        end
        en = 1'b1; up_dn = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            prev_gray = gray_out;
            step();
            exp_bin = exp_bin + 4'd1;
            if (wrap === 1'b1) wraps++;
            checks++;
            if (gray_out !== exp_gray[i] || bin_out !== exp_bin) begin
                errors++;
                $display("FAIL up_step%0d got gray=%b bin=%b exp gray=%b bin=%b", i, gray_out, bin_out, exp_gray[i], exp_bin);
            end
            checks++;
            if (wrap !== (i == 16)) begin
                errors++;
                $display("FAIL up_wrap%0d got %b exp %b", i, wrap, (i == 16));
            end
            checks++;
            if ($countones(gray_out ^ prev_gray) != 1) begin
                errors++;
                $display("FAIL up_onebit%0d got %b->%b exp one bit change", i, prev_gray, gray_out);
            end
        end
        checks++;
        if (wraps != 1) begin
            errors++;
            $display("FAIL up_wrap_count got %0d exp 1", wraps);
        end
        en = 1'b0;
    endtask

    task automatic test_count_down();
        do_reset();
        en = 1'b1; up_dn = 1'b0;
        step();
        checks++;
        if (bin_out !== 4'b1111 || gray_out !== 4'b1000 || wrap !== 1'b1) begin
            errors++;
            $display("FAIL down_first got bin=%b gray=%b wrap=%b exp 1111 1000 1", bin_out, gray_out, wrap);
        end
        step();
        checks++;
        if (bin_out !== 4'b1110 || gray_out !== 4'b1001 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL down_second got bin=%b gray=%b wrap=%b exp 1110 1001 0", bin_out, gray_out, wrap);
        end
        en = 1'b0;
    endtask

    task automatic test_load_hold();
        do_reset();
        load = 1'b1; load_bin = 4'd10;
        step();
        load = 1'b0;
        checks++;
        if (bin_out !== 4'b1010 || gray_out !== 4'b1111 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL load10 got bin=%b gray=%b wrap=%b exp 1010 1111 0", bin_out, gray_out, wrap);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bin_out !== 4'b1010 || gray_out !== 4'b1111 || wrap !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d got bin=%b gray=%b wrap=%b exp 1010 1111 0", i, bin_out, gray_out, wrap);
            end
        end
        load = 1'b1; load_bin = 4'd15;
        step();
        load = 1'b0;
        checks++;
        if (bin_out !== 4'b1111 || gray_out !== 4'b1000 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL load15 got bin=%b gray=%b wrap=%b exp 1111 1000 0", bin_out, gray_out, wrap);
        end
        // Load of zero while en would have wrapped upward: still no wrap.
        load = 1'b1; en = 1'b1; up_dn = 1'b1; load_bin = 4'd0;
        step();
        load = 1'b0; en = 1'b0;
        checks++;
        if (bin_out !== 4'b0000 || gray_out !== 4'b0000 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL load0 got bin=%b gray=%b wrap=%b exp 0000 0000 0", bin_out, gray_out, wrap);
        end
    endtask

    task automatic test_load_beats_en();
        load = 1'b1; load_bin = 4'd5;
        step();
        load = 1'b0;
        checks++;
        if (bin_out !== 4'd5 || gray_out !== 4'b0111) begin
            errors++;
            $display("FAIL load5 got bin=%b gray=%b exp 0101 0111", bin_out, gray_out);
        end
        load = 1'b1; en = 1'b1; up_dn = 1'b1; load_bin = 4'd3;
        step();
        load = 1'b0; en = 1'b0;
        checks++;
        if (bin_out !== 4'b0011 || gray_out !== 4'b0010 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL load_beats_en got bin=%b gray=%b wrap=%b exp 0011 0010 0", bin_out, gray_out, wrap);
        end
    endtask

    task automatic test_async_reset();
        load = 1'b1; load_bin = 4'd9;
        step();
        load = 1'b0;
        checks++;
        if (bin_out !== 4'd9 || gray_out !== 4'b1101) begin
            errors++;
            $display("FAIL load9 got bin=%b gray=%b exp 1001 1101", bin_out, gray_out);
        end
        en = 1'b1; up_dn = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bin_out !== 4'b0000 || gray_out !== 4'b0000 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL async_rst got bin=%b gray=%b wrap=%b exp 0000 0000 0", bin_out, gray_out, wrap);
        end
        step();
        rst = 1'b0;
        step();
        en = 1'b0;
        checks++;
        if (gray_out !== 4'b0001 || bin_out !== 4'b0001) begin
            errors++;
            $display("FAIL post_rst_step got gray=%b bin=%b exp 0001 0001", gray_out, bin_out);
        end
    endtask

    task automatic test_reversal_loopback();
        logic [3:0] exp_bin [0:5];
        logic [3:0] exp_gray [0:5];
        logic [3:0] prev_gray;
        exp_bin  = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0};
        exp_gray = '{4'b0001, 4'b0011, 4'b0010, 4'b0011, 4'b0001, 4'b0000};
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            up_dn = (i < 3);
            prev_gray = gray_out;
            step();
            checks++;
            if (bin_out !== exp_bin[i] || gray_out !== exp_gray[i] || wrap !== 1'b0) begin
                errors++;
                $display("FAIL rev_step%0d got bin=%b gray=%b wrap=%b exp bin=%b gray=%b wrap=0", i, bin_out, gray_out, wrap, exp_bin[i], exp_gray[i]);
            end
            checks++;
            if (gray2bin(gray_out) !== bin_out || $countones(gray_out ^ prev_gray) != 1) begin
                errors++;
                $display("FAIL loopback%0d got dec=%b bin=%b prev_gray=%b gray=%b exp dec==bin and one bit change", i, gray2bin(gray_out), bin_out, prev_gray, gray_out);
            end
        end
        en = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_count_up();
        test_count_down();
        test_load_hold();
        test_load_beats_en();
        test_async_reset();
        test_reversal_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout got no completion exp finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
